// File: rtl/sl811_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sl811_pkg
//  Purpose  : Shared types and constants for the SL811 bus sequencer.
//             - state_t      : bus-cycle phase encoding
//             - CNT_W        : width of the phase down-counter
//             - DEF_*_CYC    : default phase lengths in clock cycles
//             - phase_load() : counter preload for an N-cycle phase
//  Revision : 1.0 - initial release
// ============================================================================
package sl811_pkg;

    localparam int CNT_W           = 4;
    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_STROBE_CYC  = 3;
    localparam int DEF_RECOVER_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    // The counter runs N-1 down to 0, so an N-cycle phase loads N-1.
    function automatic logic [CNT_W-1:0] phase_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sl811_intrq_cond.sv
`default_nettype none
// ============================================================================
//  Module   : sl811_intrq_cond
//  Purpose  : Conditions the asynchronous SL811 intrq line.
//  Ports    : clk, rst_n       - clock, async active-low reset
//             i_sl_intrq       - raw SL811 interrupt line
//             o_int_level      - registered intrq level
//             o_int_pulse      - one-cycle pulse, one cycle after level rises
//  Config   : SL811_INTRQ_SYNC_EN defined -> extra metastability flop in front
//             of the level register (2-cycle level latency); undefined ->
//             single register (1-cycle level latency).
//  Revision : 1.0 - initial release
// ============================================================================
module sl811_intrq_cond
    import sl811_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_sl_intrq,
    output logic o_int_level,
    output logic o_int_pulse
);

    logic w_stage;
    logic r_level;
    logic r_level_d;
    logic r_pulse;

`ifdef SL811_INTRQ_SYNC_EN
    logic r_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
        end else begin
            r_meta <= i_sl_intrq;
        end
    end

    assign w_stage = r_meta;
`else
    assign w_stage = i_sl_intrq;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_level   <= w_stage;
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
        end
    end

    assign o_int_level = r_level;
    assign o_int_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/sl811_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sl811_bus_ctrl
//  Purpose  : Turns single-register requests from the ZX bus decoder into
//             timed SL811 bus cycles: SETUP -> STROBE -> HOLD -> RECOVER.
//  Ports    : clk, rst_n                     - clock, async active-low reset
//             i_req/i_rnw/i_addr/i_wdata     - request (latched in IDLE)
//             o_rdata/o_ack/o_busy           - completion side
//             i_ctl_rst_n/i_ctl_ms           - requested SL811 reset/mode
//             o_sl_cs_n/rd_n/wr_n/a0         - SL811 bus strobes / address
//             o_sl_d_out/o_sl_d_oe/i_sl_d_in - SL811 data bus
//             o_sl_rst_n/o_sl_ms             - SL811 reset and mode pins
//             i_sl_intrq, o_int_level/pulse  - conditioned interrupt
//  Config   : SL811_INTRQ_SYNC_EN selects the 2-flop intrq synchronizer.
//  Revision : 1.0 - initial release
// ============================================================================
module sl811_bus_ctrl
    import sl811_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int STROBE_CYC  = DEF_STROBE_CYC,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req,
    input  logic       i_rnw,
    input  logic       i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_ack,
    output logic       o_busy,
    input  logic       i_ctl_rst_n,
    input  logic       i_ctl_ms,
    output logic       o_sl_cs_n,
    output logic       o_sl_rd_n,
    output logic       o_sl_wr_n,
    output logic       o_sl_a0,
    output logic [7:0] o_sl_d_out,
    output logic       o_sl_d_oe,
    input  logic [7:0] i_sl_d_in,
    output logic       o_sl_rst_n,
    output logic       o_sl_ms,
    input  logic       i_sl_intrq,
    output logic       o_int_level,
    output logic       o_int_pulse
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_accept, w_capture, w_in_cycle, w_rnw_eff;

    logic             r_rnw;
    logic             r_cs_n, r_rd_n, r_wr_n, r_a0, r_d_oe, r_ack, r_busy;
    logic [7:0]       r_d_out, r_rdata;
    logic             r_sl_rst_n, r_sl_ms;

    // Next-state logic. Pin registers below are loaded from the next state so
    // every pin reflects the phase it belongs to without combinational paths.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = phase_load(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = phase_load(STROBE_CYC);
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_capture   = r_rnw;  // edge ending the last strobe cycle
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_RECOVER;
                w_cnt_nxt   = phase_load(RECOVER_CYC);
            end
            ST_RECOVER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_accept   = (r_state == ST_IDLE) && i_req;
        // On the accepting edge the direction comes straight from the request.
        w_rnw_eff  = (r_state == ST_IDLE) ? i_rnw : r_rnw;
        w_in_cycle = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                     (w_state_nxt == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rnw      <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_a0       <= 1'b0;
            r_d_oe     <= 1'b0;
            r_d_out    <= 8'h00;
            r_rdata    <= 8'h00;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_sl_rst_n <= 1'b0;
            r_sl_ms    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cs_n     <= ~w_in_cycle;
            r_rd_n     <= ~((w_state_nxt == ST_STROBE) && w_rnw_eff);
            r_wr_n     <= ~((w_state_nxt == ST_STROBE) && !w_rnw_eff);
            r_d_oe     <= w_in_cycle && !w_rnw_eff;
            r_ack      <= (w_state_nxt == ST_HOLD);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_sl_rst_n <= i_ctl_rst_n;
            r_sl_ms    <= i_ctl_ms;
            if (w_accept) begin
                r_rnw <= i_rnw;
                r_a0  <= i_addr;
                if (!i_rnw) begin
                    r_d_out <= i_wdata;
                end
            end
            if (w_capture) begin
                r_rdata <= i_sl_d_in;
            end
        end
    end

    sl811_intrq_cond u_intrq_cond (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sl_intrq  (i_sl_intrq),
        .o_int_level (o_int_level),
        .o_int_pulse (o_int_pulse)
    );

    assign o_rdata    = r_rdata;
    assign o_ack      = r_ack;
    assign o_busy     = r_busy;
    assign o_sl_cs_n  = r_cs_n;
    assign o_sl_rd_n  = r_rd_n;
    assign o_sl_wr_n  = r_wr_n;
    assign o_sl_a0    = r_a0;
    assign o_sl_d_out = r_d_out;
    assign o_sl_d_oe  = r_d_oe;
    assign o_sl_rst_n = r_sl_rst_n;
    assign o_sl_ms    = r_sl_ms;

endmodule
`default_nettype wire
